// File: rtl/execute_unit.sv
// Execute stage of a 4-bit accumulator machine.
// Three-state control FSM (FETCH, EXEC, HALT), accumulator datapath with
// carry/zero flags, 8-bit page register for jump targets and an output port.
module execute_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  instruction,
  input  logic [3:0]  operand,
  input  logic [3:0]  data_in,
  output logic        enablec,
  output logic        enablef,
  output logic        load,
  output logic [11:0] load_data,
  output logic [3:0]  accu,
  output logic        carry,
  output logic        zero,
  output logic [3:0]  out_data,
  output logic        out_valid,
  output logic        phase,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_NOP0  = 4'b0000;
  localparam logic [3:0] OP_LIT   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_NAND  = 4'b0011;
  localparam logic [3:0] OP_CMP   = 4'b0100;
  localparam logic [3:0] OP_IN    = 4'b0101;
  localparam logic [3:0] OP_OUT   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b0111;
  localparam logic [3:0] OP_PAGEH = 4'b1000;
  localparam logic [3:0] OP_PAGEL = 4'b1001;
  localparam logic [3:0] OP_JC    = 4'b1010;
  localparam logic [3:0] OP_JZ    = 4'b1011;
  localparam logic [3:0] OP_JNC   = 4'b1100;
  localparam logic [3:0] OP_JNZ   = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1110;

  state_t      state_q, state_d;
  logic [3:0]  accu_q, accu_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic [7:0]  page_q, page_d;
  logic [3:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;

  logic        jump_taken;
  logic [4:0]  sum;

  // Jump condition evaluated from the current flags; non-jumps never take.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned and infers a latch.
    jump_taken = 1'b0;
    case (instruction)
      OP_JMP:  jump_taken = 1'b1;
      OP_JC:   jump_taken = carry_q;
      OP_JZ:   jump_taken = zero_q;
      OP_JNC:  jump_taken = ~carry_q;
      OP_JNZ:  jump_taken = ~zero_q;
      default: jump_taken = 1'b0;
    endcase
  end

  assign sum = {1'b0, accu_q} + {1'b0, operand};

  // Next-state and datapath decode; registers only move on enabled cycles,
  // and the instruction is decoded only in EXEC.
  always_comb begin
    state_d     = state_q;
    accu_d      = accu_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    page_d      = page_q;
    out_data_d  = out_data_q;
    // out_valid is a single-cycle pulse, so it drops on any cycle that is not
    // the OUT execute edge, including disabled ones; this keeps a stalled
    // pipeline from presenting a second write strobe when it resumes.
    out_valid_d = 1'b0;
    if (enable) begin
      case (state_q)
        FETCH: state_d = EXEC;
        EXEC: begin
          state_d = (instruction == OP_HALT) ? HALT : FETCH;
          case (instruction)
            OP_LIT: begin
              accu_d = operand;
              zero_d = (operand == 4'b0000);
            end
            OP_ADD: begin
              accu_d  = sum[3:0];
              carry_d = sum[4];
              zero_d  = (sum[3:0] == 4'b0000);
            end
            OP_NAND: begin
              accu_d = ~(accu_q & operand);
              zero_d = ((accu_q & operand) == 4'b1111);
            end
            OP_CMP: begin
              carry_d = (accu_q >= operand);
              zero_d  = (accu_q == operand);
            end
            OP_IN: begin
              accu_d = data_in;
              zero_d = (data_in == 4'b0000);
            end
            OP_OUT: begin
              out_data_d  = accu_q;
              out_valid_d = 1'b1;
            end
            OP_PAGEH: page_d[7:4] = operand;
            OP_PAGEL: page_d[3:0] = operand;
            default: ;
          endcase
        end
        HALT:    state_d = HALT;
        default: state_d = FETCH;
      endcase
    end
  end

  // State register with synchronous reset overriding enable.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= FETCH;
      accu_q      <= 4'h0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      page_q      <= 8'h00;
      out_data_q  <= 4'h0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      accu_q      <= accu_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      page_q      <= page_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Control strobes are combinational from state, gated by enable.
  always_comb begin
    enablef = 1'b0;
    enablec = 1'b0;
    load    = 1'b0;
    if (enable) begin
      case (state_q)
        FETCH: enablef = 1'b1;
        EXEC: begin
          load    = jump_taken;
          enablec = ~jump_taken;
        end
        default: ;
      endcase
    end
  end

  assign load_data = {page_q, operand};
  assign accu      = accu_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q & enable & (state_q != HALT);
  assign phase     = (state_q == EXEC);
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_execute_unit.sv
// Directed, table-driven bench for execute_unit.
module tb_execute_unit;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [3:0]  instruction;
  logic [3:0]  operand;
  logic [3:0]  data_in;
  logic        enablec;
  logic        enablef;
  logic        load;
  logic [11:0] load_data;
  logic [3:0]  accu;
  logic        carry;
  logic        zero;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        phase;
  logic        halted;

  execute_unit dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .instruction (instruction),
    .operand     (operand),
    .data_in     (data_in),
    .enablec     (enablec),
    .enablef     (enablef),
    .load        (load),
    .load_data   (load_data),
    .accu        (accu),
    .carry       (carry),
    .zero        (zero),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .phase       (phase),
    .halted      (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] ins;
    logic [3:0] opd;
    logic [3:0] din;
    logic       tk;   // jump taken during EXEC
    logic [3:0] acc;  // accumulator after EXEC
    logic       c;
    logic       z;
    logic [7:0] pg;   // page after EXEC
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_strobes(input string tag, input logic ef, input logic ec, input logic ld);
    check({tag, ".enablef"}, {11'd0, enablef}, {11'd0, ef});
    check({tag, ".enablec"}, {11'd0, enablec}, {11'd0, ec});
    check({tag, ".load"},    {11'd0, load},    {11'd0, ld});
  endtask

  task automatic check_regs(input string tag, input logic [3:0] a, input logic c, input logic z);
    check({tag, ".accu"},  {8'd0, accu},  {8'd0, a});
    check({tag, ".carry"}, {11'd0, carry}, {11'd0, c});
    check({tag, ".zero"},  {11'd0, zero},  {11'd0, z});
  endtask

  // Drive one instruction through FETCH then EXEC, ending just after the EXEC edge.
  task automatic run_instr(input logic [3:0] ins, input logic [3:0] opd, input logic [3:0] din);
    instruction = ins;
    operand     = opd;
    data_in     = din;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{4'h1, 4'h5, 4'h6, 1'b0, 4'h5, 1'b0, 1'b0, 8'h00}; // LIT 5
    vecs[1]  = '{4'h1, 4'hF, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0, 8'h00}; // LIT F
    vecs[2]  = '{4'h2, 4'h1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 8'h00}; // ADD 1 wraps
    vecs[3]  = '{4'h1, 4'h3, 4'h0, 1'b0, 4'h3, 1'b1, 1'b0, 8'h00}; // LIT 3
    vecs[4]  = '{4'h4, 4'h3, 4'h0, 1'b0, 4'h3, 1'b1, 1'b1, 8'h00}; // CMP equal
    vecs[5]  = '{4'h8, 4'h1, 4'h0, 1'b0, 4'h3, 1'b1, 1'b1, 8'h10}; // PAGEH 1
    vecs[6]  = '{4'h9, 4'h2, 4'h0, 1'b0, 4'h3, 1'b1, 1'b1, 8'h12}; // PAGEL 2
    vecs[7]  = '{4'hB, 4'hA, 4'h0, 1'b1, 4'h3, 1'b1, 1'b1, 8'h12}; // JZ taken -> 12A
    vecs[8]  = '{4'hD, 4'h4, 4'h0, 1'b0, 4'h3, 1'b1, 1'b1, 8'h12}; // JNZ not taken
    vecs[9]  = '{4'h3, 4'h6, 4'h0, 1'b0, 4'hD, 1'b1, 1'b0, 8'h12}; // NAND 6
    vecs[10] = '{4'hA, 4'h0, 4'h0, 1'b1, 4'hD, 1'b1, 1'b0, 8'h12}; // JC taken
    vecs[11] = '{4'hC, 4'h0, 4'h0, 1'b0, 4'hD, 1'b1, 1'b0, 8'h12}; // JNC not taken
    vecs[12] = '{4'h5, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 8'h12}; // IN 0
    vecs[13] = '{4'hD, 4'h7, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 8'h12}; // JNZ not taken
    vecs[14] = '{4'hB, 4'h7, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 8'h12}; // JZ taken
    vecs[15] = '{4'h4, 4'h5, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h12}; // CMP 0<5
    vecs[16] = '{4'hC, 4'h1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h12}; // JNC taken
    vecs[17] = '{4'h7, 4'h2, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h12}; // JMP
    vecs[18] = '{4'h3, 4'hF, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0, 8'h12}; // NAND -> F
    vecs[19] = '{4'h2, 4'hF, 4'h0, 1'b0, 4'hE, 1'b1, 1'b0, 8'h12}; // ADD F+F
    vecs[20] = '{4'h2, 4'h2, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 8'h12}; // ADD E+2
    vecs[21] = '{4'h5, 4'h0, 4'h9, 1'b0, 4'h9, 1'b1, 1'b0, 8'h12}; // IN 9
    vecs[22] = '{4'h4, 4'h4, 4'h0, 1'b0, 4'h9, 1'b1, 1'b0, 8'h12}; // CMP 9>4
    vecs[23] = '{4'h0, 4'h3, 4'h0, 1'b0, 4'h9, 1'b1, 1'b0, 8'h12}; // NOP
    vecs[24] = '{4'hF, 4'h3, 4'h0, 1'b0, 4'h9, 1'b1, 1'b0, 8'h12}; // NOP
    vecs[25] = '{4'hA, 4'h5, 4'h0, 1'b1, 4'h9, 1'b1, 1'b0, 8'h12}; // JC taken
    vecs[26] = '{4'hD, 4'h5, 4'h0, 1'b1, 4'h9, 1'b1, 1'b0, 8'h12}; // JNZ taken
    vecs[27] = '{4'h9, 4'h0, 4'h0, 1'b0, 4'h9, 1'b1, 1'b0, 8'h10}; // PAGEL 0

    // Reset state, held for several cycles.
    reset = 1'b1; enable = 1'b1; instruction = 4'h1; operand = 4'h7; data_in = 4'h0;
    tick(); tick(); tick();
    check("rst.phase", {11'd0, phase}, 12'd0);
    check("rst.halted", {11'd0, halted}, 12'd0);
    check_regs("rst", 4'h0, 1'b0, 1'b0);
    check("rst.out_data", {8'd0, out_data}, 12'd0);
    check("rst.out_valid", {11'd0, out_valid}, 12'd0);
    check("rst.load_data", load_data, 12'h007);
    reset = 1'b0;

    // Table-driven FETCH/EXEC pairs.
    for (int i = 0; i < NVEC; i++) begin
      instruction = vecs[i].ins;
      operand     = vecs[i].opd;
      data_in     = vecs[i].din;
      #1;
      check($sformatf("v%0d.fetch.phase", i), {11'd0, phase}, 12'd0);
      check_strobes($sformatf("v%0d.fetch", i), 1'b1, 1'b0, 1'b0);
      tick();
      check($sformatf("v%0d.exec.phase", i), {11'd0, phase}, 12'd1);
      check_strobes($sformatf("v%0d.exec", i), 1'b0, ~vecs[i].tk, vecs[i].tk);
      if (vecs[i].ins != 4'h8 && vecs[i].ins != 4'h9)
        check($sformatf("v%0d.load_data", i), load_data, {vecs[i].pg, vecs[i].opd});
      tick();
      check_regs($sformatf("v%0d", i), vecs[i].acc, vecs[i].c, vecs[i].z);
      check($sformatf("v%0d.page", i), load_data, {vecs[i].pg, vecs[i].opd});
    end

    // OUT with accu=3: out_valid high for exactly the cycle after EXEC.
    run_instr(4'h1, 4'h3, 4'h0);
    instruction = 4'h6; operand = 4'h0;
    tick();
    check("out.exec.valid", {11'd0, out_valid}, 12'd0);
    tick();
    check("out.data", {8'd0, out_data}, 12'h003);
    check("out.valid1", {11'd0, out_valid}, 12'd1);
    instruction = 4'h0;
    tick();
    check("out.valid2", {11'd0, out_valid}, 12'd0);
    tick();
    check("out.valid3", {11'd0, out_valid}, 12'd0);
    check("out.data_hold", {8'd0, out_data}, 12'h003);

    // Enable low for 3 cycles during EXEC of LIT 7: everything frozen.
    instruction = 4'h1; operand = 4'h7;
    tick();
    check("frz.phase0", {11'd0, phase}, 12'd1);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("frz%0d.phase", k), {11'd0, phase}, 12'd1);
      check_strobes($sformatf("frz%0d", k), 1'b0, 1'b0, 1'b0);
      check_regs($sformatf("frz%0d", k), 4'h3, 1'b1, 1'b0);
    end
    enable = 1'b1;
    #1;
    check_strobes("resume", 1'b0, 1'b1, 1'b0);
    tick();
    check("resume.phase", {11'd0, phase}, 12'd0);
    check_regs("resume", 4'h7, 1'b1, 1'b0);

    // Reset asserted mid-EXEC aborts the instruction.
    instruction = 4'h1; operand = 4'h9;
    tick();
    check("abort.pre", {11'd0, phase}, 12'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort.phase", {11'd0, phase}, 12'd0);
    check_regs("abort", 4'h0, 1'b0, 1'b0);

    // HALT: sticky, all strobes low, left only by reset.
    run_instr(4'h1, 4'h4, 4'h0);
    run_instr(4'hE, 4'h0, 4'h0);
    instruction = 4'h1; operand = 4'hB;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("halt%0d.halted", k), {11'd0, halted}, 12'd1);
      check($sformatf("halt%0d.phase", k), {11'd0, phase}, 12'd0);
      check_strobes($sformatf("halt%0d", k), 1'b0, 1'b0, 1'b0);
      check($sformatf("halt%0d.out_valid", k), {11'd0, out_valid}, 12'd0);
      check_regs($sformatf("halt%0d", k), 4'h4, 1'b0, 1'b0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("unhalt.halted", {11'd0, halted}, 12'd0);
    check("unhalt.phase", {11'd0, phase}, 12'd0);
    check_regs("unhalt", 4'h0, 1'b0, 1'b0);
    check("unhalt.out_data", {8'd0, out_data}, 12'd0);
    check("unhalt.load_data", load_data, 12'h00B);
    #1;
    check_strobes("unhalt", 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: none; all widths SHALL be fixed as listed.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 enable  input  1  global run enable; low freezes all state.
REQ-006 instruction  input  4  fetched instruction nibble, i.e. opcode[7:4] from the program fetch block.
REQ-007 operand  input  4  fetched operand nibble, i.e. opcode[3:0].
REQ-008 data_in  input  4  external input port, sampled by IN.
REQ-009 enablec  output  1  program-counter increment enable.
REQ-010 enablef  output  1  fetch-register enable.
REQ-011 load  output  1  program-counter load strobe.
REQ-012 load_data  output  12  jump target {page[7:0], operand}.
REQ-013 accu  output  4  accumulator.
REQ-014 carry, zero  output  1 each  flag registers.
REQ-015 out_data  output  4  output-port register.
REQ-016 out_valid  output  1  one-cycle pulse when out_data is written.
REQ-017 phase  output  1  0 = FETCH, 1 = EXEC.
REQ-018 halted  output  1  high in HALT state.

Function
REQ-019 The FSM SHALL have states FETCH, EXEC and HALT; FETCH -> EXEC -> FETCH alternate each enabled cycle.
REQ-020 EXEC with instruction 1110 SHALL go to HALT; HALT SHALL be left only by reset.
REQ-021 In FETCH, enablef SHALL be 1 and enablec, load SHALL be 0 (combinational from state).
REQ-022 In EXEC, a taken jump SHALL drive load=1, enablec=0; every other instruction SHALL drive enablec=1, load=0; enablef SHALL be 0.
REQ-023 In HALT, or whenever enable=0, enablef, enablec, load and out_valid SHALL be 0, and no register SHALL change.
REQ-024 Instruction decode SHALL act only at the EXEC clock edge, as follows.
REQ-025 0000 / 1111 NOP: no state change other than the PC increment.
REQ-026 0001 LIT: accu <= operand; zero updated.
REQ-027 0010 ADD: {carry, accu} <= accu + operand (5-bit sum); zero updated.
REQ-028 0011 NAND: accu <= ~(accu & operand); zero updated; carry unchanged.
REQ-029 0100 CMP: accu unchanged; carry <= (accu >= operand); zero <= (accu == operand).
REQ-030 0101 IN: accu <= data_in; zero updated.
REQ-031 0110 OUT: out_data <= accu; out_valid = 1 for exactly the following cycle.
REQ-032 0111 JMP: unconditional jump.
REQ-033 1000 PAGEH: page[7:4] <= operand.
REQ-034 1001 PAGEL: page[3:0] <= operand.
REQ-035 1010 JC / 1011 JZ / 1100 JNC / 1101 JNZ: jump taken iff carry=1 / zero=1 / carry=0 / zero=0; flags are not modified.
REQ-036 load_data SHALL always equal {page, operand}, regardless of state.
REQ-037 Zero update SHALL mean zero <= (new accu == 4'b0000).
REQ-038 Arithmetic SHALL wrap modulo 16 (e.g. 15+1 gives accu=0, carry=1, zero=1).

Reset
REQ-039 When reset=1 at a clock edge, the block SHALL set state=FETCH, accu=0, carry=0, zero=0, page=0x00, out_data=0 and out_valid=0, and SHALL hold these values while reset=1.
REQ-040 Reset SHALL take priority over enable and SHALL abort any EXEC or HALT state, including a reset asserted mid-operation.

Verification
REQ-041 Reset then enable=1, instruction=0001, operand=0101 -> phase toggles 0,1,0; after EXEC, accu=5, zero=0; enablef=1 in FETCH, enablec=1 in EXEC.
REQ-042 LIT 1111, then ADD 0001 -> accu=0, carry=1, zero=1 (wrap-around).
REQ-043 LIT 0011, then CMP 0011 -> carry=1, zero=1; then JZ operand=1010 after PAGEH 0001, PAGEL 0010 -> in EXEC load=1, enablec=0, load_data=0x12A.
REQ-044 JNZ with zero=1 -> load=0, enablec=1 (not taken); then OUT with accu=3 -> out_data=3, out_valid high for one cycle only.
REQ-045 enable=0 held 3 cycles during EXEC -> phase, accu and flags frozen and all control outputs 0; enable=1 resumes with the same instruction.
REQ-046 HALT (1110) -> halted=1, all strobes 0 for 5+ cycles; reset=1 for one cycle -> halted=0, phase=0, all registers at their reset values.
